demux_1x2_32bit_buf: RTL and testbench

- Buffered 1-to-2 word distributor, the inverse of the 32-bit 2:1 select mux used in the datapath.
- Takes one 32-bit valid/ready input stream and steers each word, by a per-word 1-bit select, into one of two independently drained output queues.
- Used to route execute-stage results to two consumers (register-file write port, store/address path) that may stall independently.

---
 rtl/demux_1x2_32bit_buf_pkg.sv | 10 +
 rtl/fifo_sync_32bit.sv | 61 ++++++
 rtl/demux_1x2_32bit_buf.sv | 95 +++++++++
 tb/tb_demux_1x2_32bit_buf.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1x2_32bit_buf_pkg.sv
// Shared select encoding and datapath width, common to the 2:1 select mux
// and the 1:2 buffered distributor.
package demux_1x2_32bit_buf_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic SEL_Y0 = 1'b0;
  localparam logic SEL_Y1 = 1'b1;

endpackage

// File: rtl/fifo_sync_32bit.sv
// Single-clock FIFO. Full and empty come from the level counter, not from
// pointer compare. The head word is read straight out of registered storage.
module fifo_sync_32bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [WIDTH-1:0]         o_head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (r_level == LVL_W'(DEPTH));
  assign o_empty_c = (r_level == '0);
  assign o_level   = r_level;
  assign o_head_c  = r_mem[r_rd_ptr];

  // Illegal requests (push when full, pop when empty) are dropped here.
  assign w_push = i_push && !o_full_c;
  assign w_pop  = i_pop && !o_empty_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/demux_1x2_32bit_buf.sv
// Buffered 1:2 distributor. Each input word is steered by in_sel into one of
// two independently drained FIFOs, and per-output acceptance counters are kept.
module demux_1x2_32bit_buf
  import demux_1x2_32bit_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEFAULT,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sel,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     Y0_valid,
  input  logic                     Y0_ready,
  output logic [WIDTH-1:0]         Y0,
  output logic                     Y1_valid,
  input  logic                     Y1_ready,
  output logic [WIDTH-1:0]         Y1,
  output logic [$clog2(DEPTH):0]   Y0_level,
  output logic [$clog2(DEPTH):0]   Y1_level,
  output logic [CNT_W-1:0]         Y0_count,
  output logic [CNT_W-1:0]         Y1_count
);

  logic w_full0;
  logic w_full1;
  logic w_empty0;
  logic w_empty1;
  logic w_accept;
  logic w_push0;
  logic w_push1;
  logic w_pop0;
  logic w_pop1;
  logic [CNT_W-1:0] r_count0;
  logic [CNT_W-1:0] r_count1;

  // Ready looks only at registered fullness, so a same-cycle pop never opens it.
  assign in_ready = (in_sel == SEL_Y1) ? !w_full1 : !w_full0;
  assign w_accept = in_valid && in_ready;
  assign w_push0  = w_accept && (in_sel == SEL_Y0);
  assign w_push1  = w_accept && (in_sel == SEL_Y1);

  assign Y0_valid = !w_empty0;
  assign Y1_valid = !w_empty1;
  assign w_pop0   = Y0_valid && Y0_ready;
  assign w_pop1   = Y1_valid && Y1_ready;

  fifo_sync_32bit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_y0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push0),
    .i_push_data (in_data),
    .i_pop       (w_pop0),
    .o_full_c    (w_full0),
    .o_empty_c   (w_empty0),
    .o_level     (Y0_level),
    .o_head_c    (Y0)
  );

  fifo_sync_32bit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_y1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push1),
    .i_push_data (in_data),
    .i_pop       (w_pop1),
    .o_full_c    (w_full1),
    .o_empty_c   (w_empty1),
    .o_level     (Y1_level),
    .o_head_c    (Y1)
  );

  // Acceptance counters wrap silently and ignore pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count0 <= '0;
      r_count1 <= '0;
    end else begin
      if (w_push0) r_count0 <= r_count0 + CNT_W'(1);
      if (w_push1) r_count1 <= r_count1 + CNT_W'(1);
    end
  end

  assign Y0_count = r_count0;
  assign Y1_count = r_count1;

endmodule

// File: tb/tb_demux_1x2_32bit_buf.sv
// Directed bench for the buffered 1:2 distributor; a second narrow-counter
// instance covers counter wrap.
module tb_demux_1x2_32bit_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [31:0] in_data;
  logic        Y0_valid;
  logic        Y0_ready;
  logic [31:0] Y0;
  logic        Y1_valid;
  logic        Y1_ready;
  logic [31:0] Y1;
  logic [1:0]  Y0_level;
  logic [1:0]  Y1_level;
  logic [15:0] Y0_count;
  logic [15:0] Y1_count;

  logic        n_in_valid;
  logic        n_in_ready;
  logic        n_in_sel;
  logic [31:0] n_in_data;
  logic        n_Y0_valid;
  logic        n_Y0_ready;
  logic [31:0] n_Y0;
  logic        n_Y1_valid;
  logic        n_Y1_ready;
  logic [31:0] n_Y1;
  logic [1:0]  n_Y0_level;
  logic [1:0]  n_Y1_level;
  logic [3:0]  n_Y0_count;
  logic [3:0]  n_Y1_count;

  int n_assert;
  int n_fail;

  demux_1x2_32bit_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .Y0_valid (Y0_valid),
    .Y0_ready (Y0_ready),
    .Y0       (Y0),
    .Y1_valid (Y1_valid),
    .Y1_ready (Y1_ready),
    .Y1       (Y1),
    .Y0_level (Y0_level),
    .Y1_level (Y1_level),
    .Y0_count (Y0_count),
    .Y1_count (Y1_count)
  );

  demux_1x2_32bit_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) u_dut_c4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (n_in_valid),
    .in_ready (n_in_ready),
    .in_sel   (n_in_sel),
    .in_data  (n_in_data),
    .Y0_valid (n_Y0_valid),
    .Y0_ready (n_Y0_ready),
    .Y0       (n_Y0),
    .Y1_valid (n_Y1_valid),
    .Y1_ready (n_Y1_ready),
    .Y1       (n_Y1),
    .Y0_level (n_Y0_level),
    .Y1_level (n_Y1_level),
    .Y0_count (n_Y0_count),
    .Y1_count (n_Y1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    Y0_ready   = 1'b0;
    Y1_ready   = 1'b0;
    n_in_valid = 1'b0;
    n_in_sel   = 1'b0;
    n_in_data  = '0;
    n_Y0_ready = 1'b0;
    n_Y1_ready = 1'b0;

    tick();
    tick();
    chk("rst_y0_valid", 64'(Y0_valid), 64'h0);
    chk("rst_y1_valid", 64'(Y1_valid), 64'h0);
    chk("rst_y0_data",  64'(Y0),       64'h0);
    chk("rst_y1_data",  64'(Y1),       64'h0);
    chk("rst_levels",   64'({Y0_level, Y1_level}), 64'h0);
    chk("rst_counts",   64'({Y0_count, Y1_count}), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Steering and one-cycle latency
    Y0_ready = 1'b1;
    Y1_ready = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 32'hDEADBEEF;
    tick();
    chk("steer_y0_valid", 64'(Y0_valid), 64'h1);
    chk("steer_y0_data",  64'(Y0),       64'hDEADBEEF);
    chk("steer_y0_count", 64'(Y0_count), 64'h1);
    chk("steer_y1_idle",  64'(Y1_valid), 64'h0);
    in_sel  = 1'b1;
    in_data = 32'h12345678;
    tick();
    chk("steer_y1_valid", 64'(Y1_valid), 64'h1);
    chk("steer_y1_data",  64'(Y1),       64'h12345678);
    chk("steer_y1_count", 64'(Y1_count), 64'h1);
    chk("steer_y0_popped", 64'(Y0_valid), 64'h0);
    in_valid = 1'b0;
    tick();
    chk("steer_y1_drained", 64'(Y1_level), 64'h0);

    // Full backpressure on Y0
    Y0_ready = 1'b0;
    Y1_ready = 1'b0;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 32'h00000001;
    tick();
    in_data = 32'h00000002;
    tick();
    in_data = 32'h00000003;
    chk("full_level",    64'(Y0_level), 64'h2);
    chk("full_ready",    64'(in_ready), 64'h0);
    chk("full_head",     64'(Y0),       64'h1);
    Y0_ready = 1'b1;
    #1;
    chk("full_ready_pop", 64'(in_ready), 64'h0);
    tick();
    Y0_ready = 1'b0;
    chk("full_after_pop_level", 64'(Y0_level), 64'h1);
    chk("full_after_pop_head",  64'(Y0),       64'h2);
    chk("full_after_pop_ready", 64'(in_ready), 64'h1);
    tick();
    chk("full_third_level", 64'(Y0_level), 64'h2);
    chk("full_y0_count",    64'(Y0_count), 64'h4);

    // Independence: Y0 full and stalled, Y1 streams at one word per cycle
    in_sel   = 1'b1;
    in_data  = 32'hA0000001;
    Y1_ready = 1'b1;
    #1;
    chk("indep_ready", 64'(in_ready), 64'h1);
    tick();
    chk("indep_y1_w1", 64'(Y1), 64'hA0000001);
    in_data = 32'hA0000002;
    chk("indep_ready2", 64'(in_ready), 64'h1);
    tick();
    chk("indep_y1_w2", 64'(Y1), 64'hA0000002);
    chk("indep_y1_lvl", 64'(Y1_level), 64'h1);
    in_data = 32'hA0000003;
    tick();
    chk("indep_y1_w3",  64'(Y1), 64'hA0000003);
    chk("indep_y0_lvl", 64'(Y0_level), 64'h2);
    chk("indep_y0_head", 64'(Y0), 64'h2);

    // Push and pop at level 1: Y1 holds A, push B while A pops
    in_data = 32'hB0B0B0B0;
    tick();
    chk("pp_y1_data",  64'(Y1),       64'hB0B0B0B0);
    chk("pp_y1_valid", 64'(Y1_valid), 64'h1);
    chk("pp_y1_level", 64'(Y1_level), 64'h1);
    chk("pp_y1_count", 64'(Y1_count), 64'h5);
    in_valid = 1'b0;
    tick();
    chk("pp_y1_empty", 64'(Y1_valid), 64'h0);

    // Drain Y0 to confirm order 2 then 3
    Y0_ready = 1'b1;
    tick();
    chk("order_y0_w3", 64'(Y0), 64'h3);
    tick();
    chk("order_y0_empty", 64'(Y0_valid), 64'h0);
    chk("order_y0_count", 64'(Y0_count), 64'h4);

    // Asynchronous reset mid-stream
    Y0_ready = 1'b0;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 32'hAAAA0001;
    tick();
    in_data = 32'hAAAA0002;
    tick();
    in_valid = 1'b0;
    chk("mid_level_pre", 64'(Y0_level), 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_y0_valid", 64'(Y0_valid), 64'h0);
    chk("mid_levels",   64'({Y0_level, Y1_level}), 64'h0);
    chk("mid_counts",   64'({Y0_count, Y1_count}), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_in_ready", 64'(in_ready), 64'h1);
    chk("mid_y0_data",  64'(Y0), 64'h0);

    // Counter wrap on the 4-bit counter instance
    n_Y0_ready = 1'b1;
    n_in_valid = 1'b1;
    n_in_sel   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_in_data = 32'(i + 100);
      tick();
    end
    chk("wrap_count16", 64'(n_Y0_count), 64'h0);
    chk("wrap_head16",  64'(n_Y0),       64'd115);
    n_in_data = 32'd116;
    tick();
    n_in_valid = 1'b0;
    chk("wrap_count17", 64'(n_Y0_count), 64'h1);
    chk("wrap_y1_count", 64'(n_Y1_count), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
